// File: rtl/repeater_arbiter_pkg.sv
// Shared definitions for the hub repeat-path arbiter.
// Contents: FSM state encoding, default timing constants and a popcount helper
// that only distinguishes zero, one and two-or-more set bits.
package repeater_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRepeat  = 2'd1,
    StCollide = 2'd2
  } state_e;

  // 96 bit times at 125 MHz.
  localparam int unsigned DefaultJamMin       = 120;
  // 5 ms at 125 MHz.
  localparam int unsigned DefaultJabberCycles = 625000;
  localparam int unsigned MaxPorts            = 16;

  // Returns 0, 1 or 2 (2 meaning "two or more").
  function automatic logic [1:0] popcount_sat2(input logic [MaxPorts-1:0] vec);
    logic [1:0] cnt;
    cnt = 2'd0;
    for (int i = 0; i < MaxPorts; i++) begin
      if (vec[i]) cnt = (cnt == 2'd0) ? 2'd1 : 2'd2;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/repeater_arbiter.sv
// Repeat-path arbiter for a multi-port 100BASE-X hub.
// Picks the single active port as repeat source, jams on collision for at least
// JAM_MIN cycles and isolates a source that repeats for JABBER_CYCLES cycles.
// Ports:
//   i_clk, i_rst        hub core clock, synchronous active-high reset
//   i_rx_active         per-port carrier from the PCS receive side
//   i_link_status       per-port link up
//   o_grant             one-hot repeat source while repeating, else 0
//   o_tx_enable         ports that transmit the repeat path
//   o_jam               send jam pattern instead of repeated data
//   o_collision         collision in progress
//   o_transmitting      repeating or colliding (LED status)
//   o_jabbered          per-port isolation flags
// All outputs are registered and reflect the state entered at the last edge.
module repeater_arbiter
  import repeater_arbiter_pkg::*;
#(
  parameter int unsigned PORT_COUNT    = 4,
  parameter int unsigned JAM_MIN       = DefaultJamMin,
  parameter int unsigned JABBER_CYCLES = DefaultJabberCycles
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [PORT_COUNT-1:0] i_rx_active,
  input  logic [PORT_COUNT-1:0] i_link_status,
  output logic [PORT_COUNT-1:0] o_grant,
  output logic [PORT_COUNT-1:0] o_tx_enable,
  output logic                  o_jam,
  output logic                  o_collision,
  output logic                  o_transmitting,
  output logic [PORT_COUNT-1:0] o_jabbered
);

  localparam int unsigned SrcW = $clog2(PORT_COUNT);
  localparam int unsigned JamW = (JAM_MIN > 1) ? $clog2(JAM_MIN) : 1;
  localparam int unsigned JabW = (JABBER_CYCLES > 1) ? $clog2(JABBER_CYCLES) : 1;
  localparam logic [JamW-1:0] JamLast = JamW'(JAM_MIN - 1);
  localparam logic [JabW-1:0] JabLast = JabW'(JABBER_CYCLES - 1);

  state_e                r_state, w_state_d;
  logic [SrcW-1:0]       r_src, w_src_d;
  logic [JabW-1:0]       r_jab_cnt, w_jab_cnt_d;
  logic [JamW-1:0]       r_jam_cnt, w_jam_cnt_d;
  logic [PORT_COUNT-1:0] r_jabbered, w_jabbered_d, w_jab_set;
  logic [PORT_COUNT-1:0] w_eligible, w_src_onehot, w_others;
  logic [PORT_COUNT-1:0] w_grant_d, w_tx_enable_d;
  logic [SrcW-1:0]       w_first_idx;
  logic [1:0]            w_n;

  assign w_eligible   = i_rx_active & i_link_status & ~r_jabbered;
  assign w_n          = popcount_sat2(MaxPorts'(w_eligible));
  assign w_src_onehot = PORT_COUNT'(1) << r_src;
  assign w_others     = w_eligible & ~w_src_onehot;

  // Only used when exactly one port is eligible, so search order is irrelevant.
  always_comb begin
    w_first_idx = '0;
    for (int i = PORT_COUNT - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_first_idx = SrcW'(i);
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_src_d     = r_src;
    w_jab_cnt_d = r_jab_cnt;
    w_jam_cnt_d = r_jam_cnt;
    w_jab_set   = '0;
    unique case (r_state)
      StIdle: begin
        if (w_n == 2'd1) begin
          w_state_d   = StRepeat;
          w_src_d     = w_first_idx;
          w_jab_cnt_d = '0;
        end else if (w_n == 2'd2) begin
          w_state_d   = StCollide;
          w_jam_cnt_d = '0;
        end
      end
      StRepeat: begin
        // A newcomer wins over a source drop in the same cycle.
        if (|w_others) begin
          w_state_d   = StCollide;
          w_jam_cnt_d = '0;
        end else if (!(|(w_eligible & w_src_onehot))) begin
          w_state_d = StIdle;
        end else if (r_jab_cnt == JabLast) begin
          w_jab_set = w_src_onehot;
          w_state_d = StIdle;
        end else begin
          w_jab_cnt_d = r_jab_cnt + JabW'(1);
        end
      end
      StCollide: begin
        if (r_jam_cnt != JamLast) w_jam_cnt_d = r_jam_cnt + JamW'(1);
        if (w_n == 2'd0 && r_jam_cnt == JamLast) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // Set first, then clear on idle carrier or link loss. A port being set is
    // eligible this cycle, so set and clear never collide.
    w_jabbered_d = (r_jabbered | w_jab_set) & i_rx_active & i_link_status;

    w_grant_d = (w_state_d == StRepeat) ? (PORT_COUNT'(1) << w_src_d) : '0;
    if (w_state_d == StIdle) begin
      w_tx_enable_d = '0;
    end else begin
      w_tx_enable_d = i_link_status & ~w_jabbered_d & ~w_grant_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_src          <= '0;
      r_jab_cnt      <= '0;
      r_jam_cnt      <= '0;
      r_jabbered     <= '0;
      o_grant        <= '0;
      o_tx_enable    <= '0;
      o_jam          <= 1'b0;
      o_collision    <= 1'b0;
      o_transmitting <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_src          <= w_src_d;
      r_jab_cnt      <= w_jab_cnt_d;
      r_jam_cnt      <= w_jam_cnt_d;
      r_jabbered     <= w_jabbered_d;
      o_grant        <= w_grant_d;
      o_tx_enable    <= w_tx_enable_d;
      o_jam          <= (w_state_d == StCollide);
      o_collision    <= (w_state_d == StCollide);
      o_transmitting <= (w_state_d != StIdle);
    end
  end

  assign o_jabbered = r_jabbered;

  a_grant_onehot0: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_grant));
  a_grant_tx_excl: assert property (@(posedge i_clk) disable iff (i_rst)
                                    (o_grant & o_tx_enable) == '0);
  a_coll_jam:      assert property (@(posedge i_clk) disable iff (i_rst) o_collision |-> o_jam);
  a_coll_grant:    assert property (@(posedge i_clk) disable iff (i_rst)
                                    !(o_collision && (|o_grant)));

endmodule

// File: tb/tb_repeater_arbiter.sv
// Self-checking bench for repeater_arbiter (4 ports, JAM_MIN=8, JABBER_CYCLES=64).
// Inputs change on the falling edge; the expected outputs for the following
// rising edge are queued at the same time and compared 1 time unit after it.
module tb_repeater_arbiter;

  localparam int unsigned Ports = 4;

  typedef struct {
    string      name;
    logic [3:0] grant;
    logic [3:0] txe;
    logic       jam;
    logic       coll;
    logic       trans;
    logic [3:0] jab;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] rx;
    logic [3:0] link;
    exp_t       exp;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [Ports-1:0] rx_active;
  logic [Ports-1:0] link_status;
  logic [Ports-1:0] grant;
  logic [Ports-1:0] tx_enable;
  logic             jam;
  logic             collision;
  logic             transmitting;
  logic [Ports-1:0] jabbered;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t cur;
  vec_t tbl[10];

  repeater_arbiter #(
    .PORT_COUNT   (Ports),
    .JAM_MIN      (8),
    .JABBER_CYCLES(64)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx_active   (rx_active),
    .i_link_status (link_status),
    .o_grant       (grant),
    .o_tx_enable   (tx_enable),
    .o_jam         (jam),
    .o_collision   (collision),
    .o_transmitting(transmitting),
    .o_jabbered    (jabbered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ex(string n, logic [3:0] g, logic [3:0] t, logic j, logic c,
                              logic tr, logic [3:0] jb);
    exp_t e;
    e.name = n; e.grant = g; e.txe = t; e.jam = j; e.coll = c; e.trans = tr; e.jab = jb;
    return e;
  endfunction

  function automatic exp_t idle(string n, logic [3:0] jb);
    return ex(n, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, jb);
  endfunction

  function automatic exp_t rep(string n, logic [3:0] g, logic [3:0] t, logic [3:0] jb);
    return ex(n, g, t, 1'b0, 1'b0, 1'b1, jb);
  endfunction

  function automatic exp_t col(string n, logic [3:0] t, logic [3:0] jb);
    return ex(n, 4'b0000, t, 1'b1, 1'b1, 1'b1, jb);
  endfunction

  task automatic drive(input logic r, input logic [3:0] rx, input logic [3:0] lk, input exp_t e);
    @(negedge clk);
    rst         = r;
    rx_active   = rx;
    link_status = lk;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      checks++;
      if (grant !== cur.grant || tx_enable !== cur.txe || jam !== cur.jam ||
          collision !== cur.coll || transmitting !== cur.trans || jabbered !== cur.jab) begin
        failures++;
        $display("FAIL %s: got grant=%b txe=%b jam=%b col=%b trans=%b jab=%b, want grant=%b txe=%b jam=%b col=%b trans=%b jab=%b",
                 cur.name, grant, tx_enable, jam, collision, transmitting, jabbered,
                 cur.grant, cur.txe, cur.jam, cur.coll, cur.trans, cur.jab);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    rx_active   = '0;
    link_status = 4'b1111;

    tbl[0] = '{1'b1, 4'b0000, 4'b1111, idle("reset", 4'b0000)};
    tbl[1] = '{1'b0, 4'b0010, 4'b1101, idle("link_mask", 4'b0000)};
    tbl[2] = '{1'b0, 4'b0100, 4'b1111, rep("rep_p2", 4'b0100, 4'b1011, 4'b0000)};
    tbl[3] = '{1'b0, 4'b0100, 4'b1110, rep("link0_drop", 4'b0100, 4'b1010, 4'b0000)};
    tbl[4] = '{1'b0, 4'b0100, 4'b1010, idle("src_link_drop", 4'b0000)};
    tbl[5] = '{1'b0, 4'b0000, 4'b1111, idle("quiet", 4'b0000)};
    tbl[6] = '{1'b0, 4'b1000, 4'b1111, rep("rep_p3", 4'b1000, 4'b0111, 4'b0000)};
    tbl[7] = '{1'b0, 4'b1010, 4'b1111, col("newcomer", 4'b1111, 4'b0000)};
    tbl[8] = '{1'b1, 4'b1010, 4'b1111, idle("rst_mid_jam", 4'b0000)};
    tbl[9] = '{1'b0, 4'b0000, 4'b1111, idle("after_rst", 4'b0000)};

    for (int i = 0; i < 10; i++) drive(tbl[i].rst, tbl[i].rx, tbl[i].link, tbl[i].exp);

    // Single packet: 20 cycles of repeat from port 0.
    for (int i = 0; i < 20; i++) drive(1'b0, 4'b0001, 4'b1111, rep("pkt", 4'b0001, 4'b1110, 4'b0000));
    drive(1'b0, 4'b0000, 4'b1111, idle("pkt_end", 4'b0000));

    // Late collision: jam lasts exactly 8 cycles once carrier is gone early.
    for (int i = 0; i < 10; i++) drive(1'b0, 4'b0001, 4'b1111, rep("late_rep", 4'b0001, 4'b1110, 4'b0000));
    for (int i = 0; i < 2; i++) drive(1'b0, 4'b0011, 4'b1111, col("late_col", 4'b1111, 4'b0000));
    for (int i = 0; i < 6; i++) drive(1'b0, 4'b0000, 4'b1111, col("late_jam_min", 4'b1111, 4'b0000));
    drive(1'b0, 4'b0000, 4'b1111, idle("late_end", 4'b0000));

    // Simultaneous start: carrier longer than JAM_MIN.
    for (int i = 0; i < 20; i++) drive(1'b0, 4'b1100, 4'b1111, col("simul", 4'b1111, 4'b0000));
    drive(1'b0, 4'b0000, 4'b1111, idle("simul_end", 4'b0000));

    // Jabber on port 2.
    for (int i = 0; i < 64; i++) drive(1'b0, 4'b0100, 4'b1111, rep("jab_rep", 4'b0100, 4'b1011, 4'b0000));
    for (int i = 0; i < 36; i++) drive(1'b0, 4'b0100, 4'b1111, idle("jab_iso", 4'b0100));
    drive(1'b0, 4'b0101, 4'b1111, rep("jab_other", 4'b0001, 4'b1010, 4'b0100));
    drive(1'b0, 4'b0001, 4'b1111, rep("jab_clear", 4'b0001, 4'b1110, 4'b0000));
    drive(1'b0, 4'b0000, 4'b1111, idle("jab_done", 4'b0000));

    // Reset during a collision with port 1 isolated.
    for (int i = 0; i < 64; i++) drive(1'b0, 4'b0010, 4'b1111, rep("j1_rep", 4'b0010, 4'b1101, 4'b0000));
    drive(1'b0, 4'b0010, 4'b1111, idle("j1_iso", 4'b0010));
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b1011, 4'b1111, col("j1_col", 4'b1101, 4'b0010));
    drive(1'b1, 4'b1011, 4'b1111, idle("rst_col", 4'b0000));
    drive(1'b0, 4'b0010, 4'b1111, rep("no_residual", 4'b0010, 4'b1101, 4'b0000));
    drive(1'b1, 4'b0010, 4'b1111, idle("rst_pkt", 4'b0000));
    drive(1'b0, 4'b0000, 4'b1111, idle("final", 4'b0000));

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/repeater_arbiter.md
Name: repeater_arbiter

Overview:
- Controls the shared repeat path of the multi-port 100BASE-X hub.
- Watches per-port receive activity and decides, each cycle, which port (if any) owns the repeat path.
- Detects collisions, enforces a minimum jam duration and isolates jabbering ports.
- Drives per-port transmit enables plus the hub-level transmitting/collision status that feeds the LED blinker.

Parameters:
- PORT_COUNT, 4, number of hub ports (2..16).
- JAM_MIN, 120, minimum COLLIDE duration in clk cycles (96 bit times at 125 MHz).
- JABBER_CYCLES, 625000, maximum continuous REPEAT duration before the source is isolated (5 ms at 125 MHz).

Ports:
- clk  input  1  125 MHz clock, the hub core clock.
- rst  input  1  reset; single clock domain, synchronous, active-high.
- rx_active  input  PORT_COUNT  per-port carrier/receiving from the PCS receive side.
- link_status  input  PORT_COUNT  per-port link up.
- grant  output  PORT_COUNT  one-hot source port while in REPEAT, else 0.
- tx_enable  output  PORT_COUNT  ports that must transmit the repeat path.
- jam  output  1  transmit jam pattern instead of repeated data.
- collision  output  1  high in COLLIDE.
- transmitting  output  1  high in REPEAT or COLLIDE.
- jabbered  output  PORT_COUNT  per-port isolation flags.

Behaviour:
- Eligibility:
  - eligible[i] = rx_active[i] & link_status[i] & ~jabbered[i].
  - n = popcount(eligible), saturating compare only (0, 1, >=2).
- Registered outputs: all outputs are registered and reflect the state entered at that edge, one cycle after the inputs that caused it.
- Reset: state=IDLE; every output is 0; jabber and jam counters are 0. Reset mid-packet or mid-jam abandons it immediately, with no residual isolation.
- IDLE:
  - n==1: go to REPEAT, src = the eligible index, jabber counter = 0.
  - n>=2: go to COLLIDE, jam counter = 0.
  - n==0: stay.
- REPEAT:
  - Outputs: grant = onehot(src); tx_enable = link_status & ~jabbered & ~grant; transmitting=1; jam=0.
  - Priority, first match wins:
    - (a) Any eligible port other than src: go to COLLIDE, jam counter = 0.
    - (b) src not eligible (carrier drop or link drop): go to IDLE. Another port rising that same cycle is handled as case (a).
    - (c) Jabber counter == JABBER_CYCLES-1: set jabbered[src], go to IDLE.
    - (d) Otherwise stay and increment the jabber counter.
- COLLIDE:
  - Outputs: grant = 0; tx_enable = link_status & ~jabbered; jam=1; collision=1; transmitting=1.
  - Jam counter increments, saturating at JAM_MIN-1.
  - Go to IDLE when n==0 and the counter == JAM_MIN-1; otherwise stay.
  - Exit is never directly to REPEAT.
- Jabber clear: jabbered[i] clears on any cycle where rx_active[i]==0 or link_status[i]==0. It is never set and cleared for the same port in the same cycle; clearing is evaluated against the current inputs, after setting.
- Widths:
  - Jabber counter is $clog2(JABBER_CYCLES) bits.
  - Jam counter is $clog2(JAM_MIN) bits.
  - src is $clog2(PORT_COUNT) bits.
  - No counter ever wraps.
- Invariants, checked by assertions:
  - grant is one-hot or zero.
  - grant & tx_enable == 0.
  - collision implies jam.
  - collision and grant are never both nonzero.

Decomposition:
- Shared header/package:
  - state encoding (IDLE=0, REPEAT=1, COLLIDE=2);
  - default JAM_MIN and JABBER_CYCLES timing constants;
  - a popcount-saturate-at-2 function.
- No sub-module is natural; the block stays flat, with one state register, two counters and the jabbered vector.

Test Plan (PORT_COUNT=4, JAM_MIN=8, JABBER_CYCLES=64, all links up):
- Single packet:
  - Stimulus: rx_active=0001 for 20 cycles, then 0.
  - Response: one cycle later grant=0001, tx_enable=1110, transmitting=1 for 20 cycles; then all outputs 0.
- Late collision:
  - Stimulus: rx_active=0001 for 10 cycles, then 0011 for 2 cycles, then 0.
  - Response: REPEAT for 10 cycles, then collision=jam=1, tx_enable=1111, grant=0. COLLIDE lasts exactly 8 cycles (JAM_MIN dominates), then IDLE.
- Simultaneous start:
  - Stimulus: rx_active 0000 -> 1100, held 20 cycles.
  - Response: direct IDLE->COLLIDE, with collision held for 20 cycles (the carrier dominates JAM_MIN); IDLE one cycle after the carrier drops.
- Jabber:
  - Stimulus: rx_active=0100 held 100 cycles.
  - Response: after 64 REPEAT cycles, jabbered=0100 and state=IDLE; port 2 is then ignored while rx_active=0100 continues (grant=0, tx_enable=1011 only in later activity).
  - Stimulus: deassert port 2 for 1 cycle.
  - Response: jabbered=0000.
- Link drop and mask:
  - Stimulus: link_status=1101 with rx_active=0010.
  - Response: no grant, tx_enable=0.
  - Stimulus: link_status[0] drops during a port-2 REPEAT.
  - Response: tx_enable bit 0 clears next cycle.
  - Stimulus: link_status[2] drops.
  - Response: IDLE.
- Reset mid-operation:
  - Stimulus: assert rst during COLLIDE and with jabbered=0010.
  - Response: next cycle all outputs 0 and state IDLE, regardless of rx_active.
